// File: rtl/output_packer.sv
// Packs signed int8 results into little-endian 32-bit words and buffers them
// in a first-word-fall-through FIFO, with a flush for partial words.
module output_packer #(
    parameter int unsigned BYTE_SIZE  = 8,
    parameter int unsigned INT32_SIZE = 32,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    input  logic [BYTE_SIZE-1:0]          in_data,
    output logic                          in_ready,
    input  logic                          flush,
    output logic                          word_valid,
    output logic [INT32_SIZE-1:0]         word_data,
    input  logic                          word_pop,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic [1:0]                    partial_count,
    output logic                          flush_busy
);

    localparam int unsigned AW    = $clog2(FIFO_DEPTH);
    localparam int unsigned LW    = AW + 1;
    localparam int unsigned LANES = 4;

    logic [INT32_SIZE-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]         wptr_q, wptr_d;
    logic [AW-1:0]         rptr_q, rptr_d;
    logic [LW-1:0]         level_q, level_d;
    logic [1:0]            partial_q, partial_d;
    logic [INT32_SIZE-1:0] lanes_q, lanes_d;
    logic                  flush_busy_q, flush_busy_d;

    logic                  full;
    logic                  in_ready_c;
    logic                  accept;
    logic                  pop;
    logic                  push;
    logic                  flush_req;
    logic [2:0]            count_after;
    logic [INT32_SIZE-1:0] merged;

    // Next-state: lanes above partial_q are kept zero, so any push is zero-filled.
    always_comb begin
        full        = (level_q == LW'(FIFO_DEPTH));
        in_ready_c  = (!full || (partial_q != 2'd3)) && !flush_busy_q;
        accept      = in_valid && in_ready_c;
        pop         = word_pop && (level_q != '0);
        flush_req   = flush || flush_busy_q;
        count_after = {1'b0, partial_q} + 3'(accept);

        merged = lanes_q;
        for (int k = 0; k < int'(LANES); k++) begin
            if (accept && (partial_q == 2'(k))) begin
                merged[k*BYTE_SIZE +: BYTE_SIZE] = in_data;
            end
        end

        push         = 1'b0;
        partial_d    = partial_q;
        lanes_d      = lanes_q;
        flush_busy_d = flush_busy_q;

        if (count_after == 3'd4) begin
            push         = 1'b1;
            partial_d    = 2'd0;
            lanes_d      = '0;
            flush_busy_d = 1'b0;
        end else if (flush_req && (count_after != 3'd0)) begin
            if (!full) begin
                push         = 1'b1;
                partial_d    = 2'd0;
                lanes_d      = '0;
                flush_busy_d = 1'b0;
            end else begin
                partial_d    = count_after[1:0];
                lanes_d      = merged;
                flush_busy_d = 1'b1;
            end
        end else begin
            partial_d    = count_after[1:0];
            lanes_d      = merged;
            flush_busy_d = 1'b0;
        end

        wptr_d  = push ? wptr_q + AW'(1) : wptr_q;
        rptr_d  = pop  ? rptr_q + AW'(1) : rptr_q;
        level_d = level_q + LW'(push) - LW'(pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q       <= '0;
            rptr_q       <= '0;
            level_q      <= '0;
            partial_q    <= 2'd0;
            lanes_q      <= '0;
            flush_busy_q <= 1'b0;
        end else begin
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            level_q      <= level_d;
            partial_q    <= partial_d;
            lanes_q      <= lanes_d;
            flush_busy_q <= flush_busy_d;
        end
    end

    // Storage needs no reset: the head is masked whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q] <= merged;
        end
    end

    always_comb begin
        in_ready      = in_ready_c;
        word_valid    = (level_q != '0);
        word_data     = (level_q != '0) ? mem_q[rptr_q] : '0;
        level         = level_q;
        partial_count = partial_q;
        flush_busy    = flush_busy_q;
    end

endmodule

// File: tb/tb_output_packer.sv
// Directed bench for output_packer with a byte-to-word scoreboard queue.
module tb_output_packer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        flush;
    logic        word_valid;
    logic [31:0] word_data;
    logic        word_pop;
    logic [4:0]  level;
    logic [1:0]  partial_count;
    logic        flush_busy;

    int checks   = 0;
    int failures = 0;

    logic [31:0] exp_q[$];
    logic [31:0] m_lanes;
    int          m_part;

    always #5 clk = ~clk;

    output_packer #(.BYTE_SIZE(8), .INT32_SIZE(32), .FIFO_DEPTH(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .in_ready      (in_ready),
        .flush         (flush),
        .word_valid    (word_valid),
        .word_data     (word_data),
        .word_pop      (word_pop),
        .level         (level),
        .partial_count (partial_count),
        .flush_busy    (flush_busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Model: the byte lands in the next little-endian lane; four bytes make a word.
    task automatic model_byte(input logic [7:0] b);
        m_lanes[m_part*8 +: 8] = b;
        m_part++;
        if (m_part == 4) begin
            exp_q.push_back(m_lanes);
            m_lanes = '0;
            m_part  = 0;
        end
    endtask

    task automatic model_flush();
        if (m_part != 0) begin
            exp_q.push_back(m_lanes);
            m_lanes = '0;
            m_part  = 0;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        chk("in_ready_before_byte", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_data  = b;
        step();
        in_valid = 1'b0;
        model_byte(b);
    endtask

    task automatic do_flush();
        flush = 1'b1;
        step();
        flush = 1'b0;
        model_flush();
    endtask

    task automatic pop_word(input string tag);
        logic [31:0] exp;
        exp = (exp_q.size() != 0) ? exp_q[0] : 32'd0;
        chk({tag, "_valid"}, 32'(word_valid), 32'd1);
        chk({tag, "_data"}, word_data, exp);
        word_pop = 1'b1;
        step();
        word_pop = 1'b0;
        if (exp_q.size() != 0) void'(exp_q.pop_front());
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; flush = 1'b0; word_pop = 1'b0;
        m_lanes = '0; m_part = 0;
        step(); step();
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_partial", 32'(partial_count), 32'd0);
        chk("rst_word_valid", 32'(word_valid), 32'd0);
        chk("rst_flush_busy", 32'(flush_busy), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_word_data", word_data, 32'd0);
        rst = 1'b0;
        step();

        // Four bytes form one little-endian word.
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        chk("w1_level", 32'(level), 32'd1);
        chk("w1_data_const", word_data, 32'h4433_2211);
        pop_word("w1_pop");
        chk("w1_empty", 32'(level), 32'd0);

        // Partial word flush and empty flush.
        send_byte(8'h80); send_byte(8'h7F);
        chk("fl_partial2", 32'(partial_count), 32'd2);
        do_flush();
        chk("fl_partial0", 32'(partial_count), 32'd0);
        chk("fl_level", 32'(level), 32'd1);
        chk("fl_data_const", word_data, 32'h0000_7F80);
        pop_word("fl_pop");
        do_flush();
        chk("fl_empty_noop", 32'(level), 32'd0);

        // Flush coinciding with an accepted byte yields exactly one word.
        send_byte(8'hA5);
        in_valid = 1'b1; in_data = 8'h5A; flush = 1'b1;
        step();
        in_valid = 1'b0; flush = 1'b0;
        model_byte(8'h5A); model_flush();
        chk("flb_level", 32'(level), 32'd1);
        chk("flb_partial", 32'(partial_count), 32'd0);
        pop_word("flb_pop");

        // Fill the FIFO, then stall on the word-completing byte.
        for (int i = 0; i < 64; i++) send_byte(8'(i + 1));
        chk("full_level", 32'(level), 32'd16);
        send_byte(8'hC1); send_byte(8'hC2); send_byte(8'hC3);
        chk("full_partial3", 32'(partial_count), 32'd3);
        in_valid = 1'b1; in_data = 8'hC4;
        chk("full_in_ready", 32'(in_ready), 32'd0);
        step();
        chk("full_stall_partial", 32'(partial_count), 32'd3);
        pop_word("full_pop");
        chk("full_ready_after_pop", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        model_byte(8'hC4);
        chk("full_refill_level", 32'(level), 32'd16);
        chk("full_refill_partial", 32'(partial_count), 32'd0);

        // Flush while full waits for space.
        send_byte(8'hD1); send_byte(8'hD2);
        do_flush();
        chk("fb_busy", 32'(flush_busy), 32'd1);
        chk("fb_in_ready", 32'(in_ready), 32'd0);
        chk("fb_level", 32'(level), 32'd16);
        pop_word("fb_pop");
        step();
        chk("fb_busy_clear", 32'(flush_busy), 32'd0);
        chk("fb_level_back", 32'(level), 32'd16);
        chk("fb_partial", 32'(partial_count), 32'd0);

        // Sustained push/pop at full across pointer wrap.
        for (int w = 0; w < 16; w++) begin
            send_byte(8'(8'h40 + w)); send_byte(8'(8'h60 + w)); send_byte(8'(8'h80 + w));
            in_valid = 1'b1; in_data = 8'(8'hA0 + w);
            pop_word("wrap_pop");
            step();
            in_valid = 1'b0;
            model_byte(8'(8'hA0 + w));
            chk("wrap_level", 32'(level), 32'd16);
        end
        for (int i = 0; i < 16; i++) pop_word("drain_pop");
        chk("drain_level", 32'(level), 32'd0);
        word_pop = 1'b1;
        step();
        word_pop = 1'b0;
        chk("empty_pop_level", 32'(level), 32'd0);
        chk("empty_pop_valid", 32'(word_valid), 32'd0);

        // Asynchronous reset with stored words and a partial word.
        for (int i = 0; i < 22; i++) send_byte(8'(8'hE0 + i));
        chk("ar_level5", 32'(level), 32'd5);
        chk("ar_partial2", 32'(partial_count), 32'd2);
        #2 rst = 1'b1;
        #1;
        chk("ar_level", 32'(level), 32'd0);
        chk("ar_partial", 32'(partial_count), 32'd0);
        chk("ar_word_valid", 32'(word_valid), 32'd0);
        chk("ar_flush_busy", 32'(flush_busy), 32'd0);
        chk("ar_in_ready", 32'(in_ready), 32'd1);
        chk("ar_word_data", word_data, 32'd0);
        exp_q.delete(); m_lanes = '0; m_part = 0;
        step();
        rst = 1'b0;
        step();
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        chk("post_rst_level", 32'(level), 32'd1);
        pop_word("post_rst_pop");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
